// File: rtl/fft_ctrl_if.sv
// -----------------------------------------------------------------------------
// fft_ctrl_if
//
// Purpose
//   Bundles the FFT sequencer's system handshake (start/busy/done) with its
//   RAM/ROM/butterfly-side strobes and addresses, so the controller and its
//   neighbours connect through a single port.
//
// Signals
//   start      : launch request (system -> controller)
//   busy       : high while a transform is in progress
//   done       : one-cycle completion pulse
//   rd_en      : read strobe for both ports of the working RAM
//   rd_addr_a  : port A read address (butterfly in1)
//   rd_addr_b  : port B read address (butterfly in2)
//   tw_addr    : twiddle ROM index j, ROM[j] = W_NFFT^j
//   wr_en      : write strobe for both RAM ports
//   wr_addr_a  : destination of butterfly out1
//   wr_addr_b  : destination of butterfly out2
//   stage      : current stage index (debug / datapath scaling select)
//
// Modports
//   master : the sequencer (drives everything except start)
//   slave  : system + datapath side (drives start, observes the rest)
// -----------------------------------------------------------------------------
interface fft_ctrl_if #(
    parameter int LOG2_NFFT = 5
);
    localparam int SW = $clog2(LOG2_NFFT) + 1;

    logic                 start;
    logic                 busy;
    logic                 done;
    logic                 rd_en;
    logic [LOG2_NFFT-1:0] rd_addr_a;
    logic [LOG2_NFFT-1:0] rd_addr_b;
    logic [LOG2_NFFT-2:0] tw_addr;
    logic                 wr_en;
    logic [LOG2_NFFT-1:0] wr_addr_a;
    logic [LOG2_NFFT-1:0] wr_addr_b;
    logic [SW-1:0]        stage;

    modport master (
        input  start,
        output busy,
        output done,
        output rd_en,
        output rd_addr_a,
        output rd_addr_b,
        output tw_addr,
        output wr_en,
        output wr_addr_a,
        output wr_addr_b,
        output stage
    );

    modport slave (
        output start,
        input  busy,
        input  done,
        input  rd_en,
        input  rd_addr_a,
        input  rd_addr_b,
        input  tw_addr,
        input  wr_en,
        input  wr_addr_a,
        input  wr_addr_b,
        input  stage
    );
endinterface

// File: rtl/fft_ctrl.sv
// -----------------------------------------------------------------------------
// fft_ctrl
//
// Purpose
//   Sequencer for an in-place radix-2 decimation-in-time FFT. Walks every
//   stage s of an NFFT-point transform, issuing one butterfly per cycle:
//   a read-address pair plus twiddle index to the dual-port working RAM and
//   twiddle ROM, followed one cycle later by the matching write-back.
//   Input samples are expected in the RAM already in bit-reversed order.
//
// Ports
//   clk    : single clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : fft_ctrl_if.master (start in; busy/done, read/write strobes,
//            read/write addresses, twiddle index and stage out)
//
// Parameters
//   LOG2_NFFT : log2 of transform size, legal range 2..10
// -----------------------------------------------------------------------------
module fft_ctrl #(
    parameter int LOG2_NFFT = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    fft_ctrl_if.master   bus
);

    localparam int AW = LOG2_NFFT;                 // RAM address width
    localparam int KW = LOG2_NFFT - 1;             // butterfly counter / twiddle width
    localparam int SW = $clog2(LOG2_NFFT) + 1;     // stage counter width

    localparam logic [KW-1:0] K_LAST = '1;                   // NFFT/2 - 1
    localparam logic [SW-1:0] S_LAST = SW'(LOG2_NFFT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [KW-1:0] k_q, k_d;

    // Registered outputs and their next values
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rd_en_q, rd_en_d;
    logic [AW-1:0] rd_addr_a_q, rd_addr_a_d;
    logic [AW-1:0] rd_addr_b_q, rd_addr_b_d;
    logic [KW-1:0] tw_addr_q, tw_addr_d;
    logic          wr_en_q;
    logic [AW-1:0] wr_addr_a_q;
    logic [AW-1:0] wr_addr_b_q;

    // -------------------------------------------------------------------------
    // Per-stage address candidates. Each stage has fixed shift amounts, so
    // every candidate is plain wiring on k; a final mux on the stage index
    // picks one. This avoids variable barrel shifters on the critical path.
    //   half = 2^s, pos = k mod half, grp = k >> s
    //   a    = grp*2*half + pos, b = a + half, tw = pos << (LOG2_NFFT-1-s)
    // -------------------------------------------------------------------------
    logic [LOG2_NFFT-1:0][AW-1:0] cand_a;
    logic [LOG2_NFFT-1:0][AW-1:0] cand_b;
    logic [LOG2_NFFT-1:0][KW-1:0] cand_tw;

    for (genvar gi = 0; gi < LOG2_NFFT; gi++) begin : g_stage
        localparam logic [KW-1:0] POS_MASK = KW'((1 << gi) - 1);
        localparam logic [AW-1:0] HALF     = AW'(1 << gi);

        logic [KW-1:0] pos;
        logic [KW-1:0] grp;

        assign pos = k_d & POS_MASK;
        assign grp = k_d >> gi;

        // pos < half, so OR-ing the fields is the same as adding them
        assign cand_a[gi]  = (AW'(grp) << (gi + 1)) | AW'(pos);
        assign cand_b[gi]  = cand_a[gi] | HALF;
        assign cand_tw[gi] = pos << (KW - gi);
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_RUN;
                    s_d     = '0;
                    k_d     = '0;
                end
            end
            ST_RUN: begin
                if (k_q == K_LAST) begin
                    state_d = ST_GAP;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_GAP: begin
                // One bubble lets the last write of this stage land before
                // the next stage can read that location.
                if (s_q == S_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                    s_d     = s_q + 1'b1;
                    k_d     = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode from the next state, so every output is a flop and
    // reflects the state being entered on the same edge.
    // -------------------------------------------------------------------------
    always_comb begin
        rd_en_d     = (state_d == ST_RUN);
        busy_d      = (state_d == ST_RUN) || (state_d == ST_GAP);
        done_d      = (state_d == ST_DONE);
        rd_addr_a_d = '0;
        rd_addr_b_d = '0;
        tw_addr_d   = '0;

        if (rd_en_d) begin
            for (int i = 0; i < LOG2_NFFT; i++) begin
                if (s_d == SW'(i)) begin
                    rd_addr_a_d = cand_a[i];
                    rd_addr_b_d = cand_b[i];
                    tw_addr_d   = cand_tw[i];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            k_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            tw_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_a_q <= '0;
            wr_addr_b_q <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            k_q         <= k_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            tw_addr_q   <= tw_addr_d;
            // RAM read latency is one cycle and the butterfly is
            // combinational, so write-back trails the read by one stage.
            wr_en_q     <= rd_en_q;
            wr_addr_a_q <= rd_addr_a_q;
            wr_addr_b_q <= rd_addr_b_q;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rd_en     = rd_en_q;
    assign bus.rd_addr_a = rd_addr_a_q;
    assign bus.rd_addr_b = rd_addr_b_q;
    assign bus.tw_addr   = tw_addr_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr_a = wr_addr_a_q;
    assign bus.wr_addr_b = wr_addr_b_q;
    assign bus.stage     = s_q;

endmodule

// File: tb/tb_fft_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft_ctrl
//
// Directed sequence for fft_ctrl (NFFT=32): reset behaviour, full-run cycle
// schedule, ignored starts, back-to-back restart, mid-run abort, and two
// numeric runs (impulse and random input) through a RAM + butterfly model
// driven by the controller, compared against a direct DFT.
// -----------------------------------------------------------------------------
module tb_fft_ctrl;

    localparam int  L        = 5;
    localparam int  N        = 1 << L;
    localparam int  H        = N / 2;
    localparam int  DONE_CYC = 1 + L * (H + 1);   // 86 for NFFT=32
    localparam real PI       = 3.14159265358979323846;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    fft_ctrl_if #(.LOG2_NFFT(L)) bus ();

    fft_ctrl #(.LOG2_NFFT(L)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // RAM + butterfly model driven by the controller's strobes.
    // Reads latch data; the write one cycle later applies the butterfly.
    // ------------------------------------------------------------------
    real ram_re [N];
    real ram_im [N];
    real init_re [N];
    real init_im [N];
    int  load_seq  = 0;
    int  load_seen = 0;
    real lat_ar = 0.0, lat_ai = 0.0, lat_br = 0.0, lat_bi = 0.0;
    int  lat_tw = 0;

    always @(negedge clk) begin : ram_model
        real c, sn, tr, ti;
        if (load_seq != load_seen) begin
            for (int i = 0; i < N; i++) begin
                ram_re[i] <= init_re[i];
                ram_im[i] <= init_im[i];
            end
            load_seen <= load_seq;
        end else begin
            if (bus.wr_en) begin
                c  = $cos(2.0 * PI * lat_tw / N);
                sn = $sin(2.0 * PI * lat_tw / N);
                // t = in2 * W^j, W = exp(-i*2*pi/N)
                tr = lat_br * c + lat_bi * sn;
                ti = lat_bi * c - lat_br * sn;
                ram_re[bus.wr_addr_a] <= lat_ar + tr;
                ram_im[bus.wr_addr_a] <= lat_ai + ti;
                ram_re[bus.wr_addr_b] <= lat_ar - tr;
                ram_im[bus.wr_addr_b] <= lat_ai - ti;
            end
            if (bus.rd_en) begin
                lat_ar <= ram_re[bus.rd_addr_a];
                lat_ai <= ram_im[bus.rd_addr_a];
                lat_br <= ram_re[bus.rd_addr_b];
                lat_bi <= ram_im[bus.rd_addr_b];
                lat_tw <= int'(bus.tw_addr);
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Expected controller outputs in cycle cyc (cycle 0 = start sampled).
    // Each stage is H read cycles followed by one bubble cycle.
    function automatic void sched(input int cyc, output bit rd, output int a,
                                  output int b, output int tw, output bit bz,
                                  output bit dn, output int st);
        int t, k, half;
        rd = 0; a = 0; b = 0; tw = 0; st = 0;
        bz = (cyc >= 1) && (cyc < DONE_CYC);
        dn = (cyc == DONE_CYC);
        if (bz) begin
            t  = cyc - 1;
            st = t / (H + 1);
            k  = t % (H + 1);
            if (k < H) begin
                rd   = 1;
                half = 1 << st;
                a    = (k / half) * 2 * half + (k % half);
                b    = a + half;
                tw   = (k % half) * (H / half);
            end
        end
    endfunction

    function automatic int bitrev(input int x);
        int r = 0;
        for (int i = 0; i < L; i++) r |= ((x >> i) & 1) << (L - 1 - i);
        return r;
    endfunction

    function automatic int rnd_milli(input real r);
        return (r >= 0.0) ? $rtoi(r * 1000.0 + 0.5) : -$rtoi(-r * 1000.0 + 0.5);
    endfunction

    function automatic real fabs(input real r);
        return (r < 0.0) ? -r : r;
    endfunction

    task automatic check_all_zero(input string ctx);
        check({ctx, "_busy"},  32'(bus.busy),      0);
        check({ctx, "_done"},  32'(bus.done),      0);
        check({ctx, "_rd_en"}, 32'(bus.rd_en),     0);
        check({ctx, "_wr_en"}, 32'(bus.wr_en),     0);
        check({ctx, "_rd_a"},  32'(bus.rd_addr_a), 0);
        check({ctx, "_rd_b"},  32'(bus.rd_addr_b), 0);
        check({ctx, "_tw"},    32'(bus.tw_addr),   0);
        check({ctx, "_wr_a"},  32'(bus.wr_addr_a), 0);
        check({ctx, "_wr_b"},  32'(bus.wr_addr_b), 0);
        check({ctx, "_stage"}, 32'(bus.stage),     0);
    endtask

    // Called just after a negedge in IDLE: that cycle becomes cycle 0.
    task automatic run_transform(input bit poke, input int abort_at);
        bit rd, bz, dn, prd, pbz, pdn;
        int a, b, tw, st, pa, pb, ptw, pst;
        int rd_cnt = 0;
        int wr_cnt = 0;
        bus.start = 1'b1;
        for (int cyc = 1; cyc <= DONE_CYC; cyc++) begin
            @(negedge clk);
            sched(cyc,     rd,  a,  b,  tw,  bz,  dn,  st);
            sched(cyc - 1, prd, pa, pb, ptw, pbz, pdn, pst);
            check($sformatf("busy@%0d",  cyc), 32'(bus.busy),  32'(bz));
            check($sformatf("done@%0d",  cyc), 32'(bus.done),  32'(dn));
            check($sformatf("rd_en@%0d", cyc), 32'(bus.rd_en), 32'(rd));
            check($sformatf("wr_en@%0d", cyc), 32'(bus.wr_en), 32'(prd));
            if (rd) begin
                check($sformatf("rd_a@%0d",  cyc), 32'(bus.rd_addr_a), a);
                check($sformatf("rd_b@%0d",  cyc), 32'(bus.rd_addr_b), b);
                check($sformatf("tw@%0d",    cyc), 32'(bus.tw_addr),   tw);
                check($sformatf("stage@%0d", cyc), 32'(bus.stage),     st);
            end
            if (prd) begin
                check($sformatf("wr_a@%0d", cyc), 32'(bus.wr_addr_a), pa);
                check($sformatf("wr_b@%0d", cyc), 32'(bus.wr_addr_b), pb);
            end
            rd_cnt += int'(bus.rd_en);
            wr_cnt += int'(bus.wr_en);
            // start pulses while busy or in DONE must be ignored
            bus.start = (poke && (cyc == 10 || cyc == DONE_CYC)) ? 1'b1 : 1'b0;
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero($sformatf("abort@%0d", cyc));
                repeat (DONE_CYC - abort_at + 5) begin
                    @(negedge clk);
                    check("abort_no_done",  32'(bus.done),  0);
                    check("abort_no_wr_en", 32'(bus.wr_en), 0);
                    check("abort_no_rd_en", 32'(bus.rd_en), 0);
                end
                return;
            end
        end
        check("total_rd_en", rd_cnt, L * H);
        check("total_wr_en", wr_cnt, L * H);
    endtask

    task automatic load_ram();
        @(negedge clk);
        load_seq++;
        @(negedge clk);
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin : stimulus
        int amp;
        int xr [N];
        int xi [N];
        real er, ei;
        bit ok;

        bus.start = 1'b1;
        for (int i = 0; i < N; i++) begin
            init_re[i] = 0.0;
            init_im[i] = 0.0;
            ram_re[i]  = 0.0;
            ram_im[i]  = 0.0;
        end

        // Reset held with start high: everything quiet
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // Release reset with start still high: transform starts at once,
        // with start pokes in cycles 10 and 86 that must be ignored
        rst_n = 1'b1;
        run_transform(1'b1, 0);

        // Cycle 87: IDLE, nothing issued despite the poke in DONE
        @(negedge clk);
        check("idle87_rd_en", 32'(bus.rd_en), 0);
        check("idle87_busy",  32'(bus.busy),  0);
        check("idle87_done",  32'(bus.done),  0);
        // Restart accepted in this IDLE cycle -> rd_en in cycle 88
        run_transform(1'b0, 0);

        // Abort in cycle 40 of a fresh run
        @(negedge clk);
        run_transform(1'b0, 40);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_abort_busy", 32'(bus.busy), 0);

        // Unit-impulse run: every bin equals the impulse amplitude
        amp = int'($urandom_range(1, 1000));
        for (int i = 0; i < N; i++) begin
            init_re[i] = 0.0;
            init_im[i] = 0.0;
        end
        init_re[bitrev(0)] = real'(amp);
        load_ram();
        run_transform(1'b0, 0);
        for (int i = 0; i < N; i++) begin
            check($sformatf("imp_re[%0d]", i), rnd_milli(ram_re[i]), amp * 1000);
            check($sformatf("imp_im[%0d]", i), rnd_milli(ram_im[i]), 0);
        end

        // Random input vs. direct DFT
        @(negedge clk);
        for (int n = 0; n < N; n++) begin
            xr[n] = int'($urandom_range(0, 200)) - 100;
            xi[n] = int'($urandom_range(0, 200)) - 100;
            init_re[bitrev(n)] = real'(xr[n]);
            init_im[bitrev(n)] = real'(xi[n]);
        end
        load_ram();
        run_transform(1'b0, 0);
        for (int k = 0; k < N; k++) begin
            er = 0.0;
            ei = 0.0;
            for (int n = 0; n < N; n++) begin
                er += xr[n] * $cos(2.0 * PI * n * k / N) + xi[n] * $sin(2.0 * PI * n * k / N);
                ei += xi[n] * $cos(2.0 * PI * n * k / N) - xr[n] * $sin(2.0 * PI * n * k / N);
            end
            ok = (fabs(ram_re[k] - er) < 0.01) && (fabs(ram_im[k] - ei) < 0.01);
            check($sformatf("dft_bin[%0d]_within_tol", k), 32'(ok), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
